// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg : shared types and helpers for the parametrised FIFO
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int cnt_bits(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem : WIDTH x DEPTH storage, synchronous write, asynchronous read
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl : synchronous FIFO with count, almost flags, flush, sticky errors
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int         DEPTH      = 16,
  parameter int         WIDTH      = 8,
  parameter fifo_mode_e MODE       = FIFO_STD,
  parameter int         AFULL_LVL  = DEPTH - 2,
  parameter int         AEMPTY_LVL = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             in,
  input  logic                         wr_en,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             out,
  output logic [cnt_bits(DEPTH)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_bits(DEPTH);
  localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
  localparam logic [CW-1:0] C_AFULL  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] C_AEMPTY = CW'(AEMPTY_LVL);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
    $error("fifo_ctrl: DEPTH must be a power of two and >= 2");
  end
  if (AFULL_LVL > DEPTH || AEMPTY_LVL > DEPTH) begin : g_chk_levels
    $error("fifo_ctrl: AFULL_LVL and AEMPTY_LVL must be <= DEPTH");
  end

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;
  logic             w_empty;
  logic             w_full;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [WIDTH-1:0] w_head;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == C_DEPTH);
  assign w_rd_acc = rd_en && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign w_wr_acc = wr_en && (!w_full || rd_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + CW'(1);
      else if (w_rd_acc && !w_wr_acc) r_count <= r_count - CW'(1);
      if (wr_en && w_full && !rd_en) r_overflow  <= 1'b1;
      if (rd_en && w_empty)          r_underflow <= 1'b1;
    end
  end

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_acc && !flush && !rst),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (in),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_head)
  );

  if (MODE == FIFO_FWFT) begin : g_fwft
    assign out = w_empty ? '0 : w_head;
  end else begin : g_std
    logic [WIDTH-1:0] r_out;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_out <= '0;
      end else if (!flush && w_rd_acc) begin
        r_out <= w_head;
      end
    end
    assign out = r_out;
  end

  assign count        = r_count;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_full  = (r_count >= C_AFULL);
  assign almost_empty = (r_count <= C_AEMPTY);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_ctrl : directed bench driving a FIFO_STD and a FIFO_FWFT instance
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fifo_ctrl;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] din = 8'h00;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;

  logic [7:0] s_out, f_out;
  logic [4:0] s_count, f_count;
  logic       s_empty, s_full, s_af, s_ae, s_ov, s_un;
  logic       f_empty, f_full, f_af, f_ae, f_ov, f_un;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fifo_ctrl #(.DEPTH(16), .WIDTH(8), .MODE(FIFO_STD), .AFULL_LVL(14), .AEMPTY_LVL(2)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .in(din), .wr_en(wr_en), .rd_en(rd_en),
    .out(s_out), .count(s_count), .empty(s_empty), .full(s_full),
    .almost_full(s_af), .almost_empty(s_ae), .overflow(s_ov), .underflow(s_un)
  );

  fifo_ctrl #(.DEPTH(16), .WIDTH(8), .MODE(FIFO_FWFT), .AFULL_LVL(14), .AEMPTY_LVL(2)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .in(din), .wr_en(wr_en), .rd_en(rd_en),
    .out(f_out), .count(f_count), .empty(f_empty), .full(f_full),
    .almost_full(f_af), .almost_empty(f_ae), .overflow(f_ov), .underflow(f_un)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    tests++; if (s_count !== 5'd0 || f_count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d/%0d want 0", s_count, f_count); end
    tests++; if ({s_empty, s_full, s_ae, s_af} !== 4'b1010) begin fails++; $display("FAIL reset_flags: got e/f/ae/af=%b want 1010", {s_empty, s_full, s_ae, s_af}); end
    tests++; if (s_out !== 8'h00 || f_out !== 8'h00) begin fails++; $display("FAIL reset_out: got %h/%h want 00", s_out, f_out); end
    tests++; if ({s_ov, s_un, f_ov, f_un} !== 4'b0000) begin fails++; $display("FAIL reset_err: got %b want 0000", {s_ov, s_un, f_ov, f_un}); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      din = 8'(8'h11 + i); wr_en = 1'b1;
      tick();
      tests++; if (s_count !== 5'(i + 1)) begin fails++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, s_count, i + 1); end
      tests++; if (s_af !== ((i + 1) >= 14) || s_ae !== ((i + 1) <= 2) || s_full !== ((i + 1) == 16))
        begin fails++; $display("FAIL fill_flags[%0d]: got af/ae/full=%b%b%b", i, s_af, s_ae, s_full); end
      tests++; if (f_out !== 8'h11 || f_empty !== 1'b0) begin fails++; $display("FAIL fill_fwft_head[%0d]: got %h empty=%b want 11 empty=0", i, f_out, f_empty); end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_overflow();
    din = 8'hAA; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tests++; if (s_ov !== 1'b1 || f_ov !== 1'b1) begin fails++; $display("FAIL overflow_flag: got %b/%b want 1", s_ov, f_ov); end
    tests++; if (s_count !== 5'd16 || s_full !== 1'b1) begin fails++; $display("FAIL overflow_count: got %0d want 16", s_count); end
  endtask

  task automatic test_drain_std();
    logic [7:0] exp_f;
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      tick();
      exp_f = (i < 15) ? 8'(8'h12 + i) : 8'h00;
      tests++; if (s_out !== 8'(8'h11 + i)) begin fails++; $display("FAIL drain_std_out[%0d]: got %h want %h", i, s_out, 8'(8'h11 + i)); end
      tests++; if (f_out !== exp_f) begin fails++; $display("FAIL drain_fwft_out[%0d]: got %h want %h", i, f_out, exp_f); end
      tests++; if (s_count !== 5'(15 - i)) begin fails++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, s_count, 15 - i); end
    end
    rd_en = 1'b0;
    tick();
    tests++; if (s_empty !== 1'b1 || s_out !== 8'h20) begin fails++; $display("FAIL drain_end: got empty=%b out=%h want 1/20", s_empty, s_out); end
    tests++; if (s_ov !== 1'b1 || s_un !== 1'b0) begin fails++; $display("FAIL drain_sticky: got ov=%b un=%b want 1/0", s_ov, s_un); end
  endtask

  task automatic test_empty_rw();
    din = 8'h33; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b0;
    tests++; if (s_un !== 1'b1 || s_count !== 5'd1) begin fails++; $display("FAIL empty_rw_state: got un=%b count=%0d want 1/1", s_un, s_count); end
    tests++; if (s_out !== 8'h20 || f_out !== 8'h33) begin fails++; $display("FAIL empty_rw_out: got std=%h fwft=%h want 20/33", s_out, f_out); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tests++; if (s_out !== 8'h33 || s_empty !== 1'b1) begin fails++; $display("FAIL empty_rw_read: got %h empty=%b want 33/1", s_out, s_empty); end
  endtask

  task automatic test_fwft();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests++; if ({s_ov, s_un} !== 2'b00 || s_out !== 8'h33) begin fails++; $display("FAIL fwft_flush: got ov/un=%b out=%h want 00/33", {s_ov, s_un}, s_out); end
    din = 8'h5A; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tests++; if (f_out !== 8'h5A || f_empty !== 1'b0) begin fails++; $display("FAIL fwft_visible: got %h empty=%b want 5a/0", f_out, f_empty); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tests++; if (f_out !== 8'h00 || f_empty !== 1'b1) begin fails++; $display("FAIL fwft_pop: got %h empty=%b want 00/1", f_out, f_empty); end
    tests++; if (s_out !== 8'h5A) begin fails++; $display("FAIL fwft_std_pop: got %h want 5a", s_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_s, exp_f;
    for (int i = 0; i < 16; i++) begin
      din = 8'(8'h80 + i); wr_en = 1'b1;
      tick();
    end
    tests++; if (s_full !== 1'b1) begin fails++; $display("FAIL b2b_full: got %b want 1", s_full); end
    for (int k = 0; k < 20; k++) begin
      din = 8'(8'hC0 + k); wr_en = 1'b1; rd_en = 1'b1;
      tick();
      exp_s = (k < 16) ? 8'(8'h80 + k) : 8'(8'hC0 + k - 16);
      exp_f = (k + 1 < 16) ? 8'(8'h80 + k + 1) : 8'(8'hC0 + k + 1 - 16);
      tests++; if (s_out !== exp_s || f_out !== exp_f) begin fails++; $display("FAIL b2b_out[%0d]: got %h/%h want %h/%h", k, s_out, f_out, exp_s, exp_f); end
      tests++; if (s_count !== 5'd16 || s_ov !== 1'b0) begin fails++; $display("FAIL b2b_state[%0d]: got count=%0d ov=%b want 16/0", k, s_count, s_ov); end
    end
    wr_en = 1'b0;
    for (int j = 0; j < 16; j++) begin
      tick();
      tests++; if (s_out !== 8'(8'hC4 + j)) begin fails++; $display("FAIL b2b_drain[%0d]: got %h want %h", j, s_out, 8'(8'hC4 + j)); end
    end
    rd_en = 1'b0;
    tests++; if (s_empty !== 1'b1 || s_un !== 1'b0) begin fails++; $display("FAIL b2b_end: got empty=%b un=%b want 1/0", s_empty, s_un); end
  endtask

  task automatic test_flush();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = 8'(8'h01 + i); wr_en = 1'b1;
      tick();
    end
    din = 8'h77; flush = 1'b1;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    tests++; if (s_count !== 5'd0 || s_empty !== 1'b1) begin fails++; $display("FAIL flush_count: got %0d empty=%b want 0/1", s_count, s_empty); end
    tests++; if ({s_ov, s_un, f_ov, f_un} !== 4'b0000) begin fails++; $display("FAIL flush_err: got %b want 0000", {s_ov, s_un, f_ov, f_un}); end
    tests++; if (f_out !== 8'h00) begin fails++; $display("FAIL flush_fwft_out: got %h want 00", f_out); end
    din = 8'h99; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    tests++; if (s_out !== 8'h99 || s_empty !== 1'b1) begin fails++; $display("FAIL flush_readback: got %h empty=%b want 99/1", s_out, s_empty); end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 3; i++) begin
      din = 8'(8'hE0 + i); wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    tests++; if (s_out !== 8'hE0) begin fails++; $display("FAIL rst_pre_read: got %h want e0", s_out); end
    rd_en = 1'b1; wr_en = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
    tests++; if (s_count !== 5'd0 || {s_empty, s_full, s_ae, s_af} !== 4'b1010) begin fails++; $display("FAIL rst_mid_state: got count=%0d flags=%b want 0/1010", s_count, {s_empty, s_full, s_ae, s_af}); end
    tests++; if (s_out !== 8'h00 || f_out !== 8'h00 || {s_ov, s_un} !== 2'b00) begin fails++; $display("FAIL rst_mid_out: got %h/%h err=%b want 00/00/00", s_out, f_out, {s_ov, s_un}); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain_std();
    test_empty_rw();
    test_fwft();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_ctrl.md
# fifo_ctrl

Parametrised synchronous FIFO that supersedes the basic byte FIFO in the UPDI datapath (host-side TX/RX byte buffering between the UART front end and the UPDI command engine). It uses all DEPTH entries, exposes an occupancy count and programmable almost-full/almost-empty flags, and supports both registered-read and first-word-fall-through (FWFT) modes. It adds a synchronous flush and sticky overflow/underflow error flags.

## Interface
- DEPTH, 16, number of entries; power of two, >= 2
- WIDTH, 8, bits per entry
- MODE, FIFO_STD, read mode: FIFO_STD (registered read) or FIFO_FWFT (head visible on out)
- AFULL_LVL, DEPTH-2, almost_full asserts when count >= AFULL_LVL
- AEMPTY_LVL, 2, almost_empty asserts when count <= AEMPTY_LVL
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  reset; synchronous, active-high
- flush  in  1  synchronous empty request
- in  in  WIDTH  write data
- wr_en  in  1  write request
- rd_en  in  1  read/pop request
- out  out  WIDTH  read data
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count >= AFULL_LVL
- almost_empty  out  1  count <= AEMPTY_LVL
- overflow  out  1  sticky; a write was dropped
- underflow  out  1  sticky; a read hit empty

## Operation
- Reset: pointers 0, count 0, out 0, overflow 0, underflow 0. So empty=1, full=0, almost_empty=1, and almost_full=(AFULL_LVL==0).
- Read is accepted iff rd_en && !empty.
- Write is accepted iff wr_en && (!full || rd_en). A simultaneous read and write is therefore legal when full.
- When empty with rd_en && wr_en: the read is rejected (underflow set), the write is accepted, and count becomes 1.
- count: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Full and empty are derived from count, never from pointer compare.
- FIFO_STD: on an accepted read, out <= head at that edge. Otherwise out holds its value.
- FIFO_FWFT: out = empty ? 0 : memory[rd_ptr], combinational from state. rd_en pops the displayed word.
- overflow sets on wr_en && full && !rd_en. underflow sets on rd_en && empty. Both clear only on rst or flush.
- flush: pointers and count go to 0 and both error flags clear. rd_en/wr_en in the same cycle are ignored, with no error flagged. In FIFO_STD, out holds its value.
- rst has priority over flush; flush has priority over rd/wr.
- Storage contents are never reset.

## Timing
- All status outputs (count, empty, full, almost_*, error flags) are registered or decoded from registered count. They reflect the state after the edge.
- FIFO_STD read latency: 1 cycle. Data is on out after the edge where the read was accepted.
- FIFO_FWFT: a word written at edge N is visible on out with empty=0 after edge N. The pop takes effect at the edge with rd_en high.
- Write to read-visible latency is 1 edge in both modes. There is no bypass of in to out within a cycle.
- Throughput: one write and one read per cycle sustained, including at full and at empty+write.

## Structure
- Shared package fifo_pkg contains:
  - typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT}
  - a function cnt_bits(depth) returning $clog2(depth+1)
- One sub-module, fifo_mem: simple dual-port array with WIDTH×DEPTH storage, a synchronous write port, and an asynchronous read address port.
  - fifo_ctrl instantiates fifo_mem and selects registered or combinational out per MODE.
- Parameter checks: elaboration-time assertion that DEPTH is a power of two and that AFULL_LVL and AEMPTY_LVL are <= DEPTH.

## Test plan
- Reset then idle, DEPTH=16: count=0, empty=1, out=0, errors=0. Write 0x11..0x20 (16 words) -> full=1, count=16, almost_full asserted from count=14.
- While full, wr_en=1 only with in=0xAA -> overflow=1, count stays 16, and the 0xAA is never read back. Drain 16 reads in FIFO_STD -> out sequence 0x11..0x20, each one cycle after its rd_en, then empty=1.
- FIFO_FWFT: write 0x5A to empty -> next cycle out=0x5A, empty=0. Pulse rd_en -> out=0, empty=1.
- When full, rd_en=wr_en=1 for 20 cycles with an incrementing pattern -> count stays 16, no overflow, order preserved across pointer wrap.
- When empty, rd_en=wr_en=1 with in=0x33 -> underflow=1, count=1, and the next read returns 0x33.
- Fill 5 words, assert flush together with wr_en -> count=0, empty=1, overflow=underflow=0, and the flushed data is not readable. Assert rst mid-stream -> all outputs return to their reset values.
